// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
// Writer-side front end for the 32x64 register file. Writeback requests are
// buffered in a small circular queue and drained one per cycle into a
// registered write port (RegWr/RW/BusW), which stays stable for the whole
// cycle so the register file can commit it on the falling edge. Two
// combinational lookups (RA/RB) return the newest value still pending in the
// queue or in the write-port stage, so read muxes never see stale data.

module regfile_writeback_queue #(
    parameter int DEPTH = 4,   // queue entries, power of two, >= 2
    parameter int PTRW  = 2    // log2(DEPTH)
) (
    input  logic            Clk,
    input  logic            Reset_L,
    // request side
    input  logic            WrValid,
    output logic            WrReady,
    input  logic [4:0]      WrReg,
    input  logic [63:0]     WrData,
    // drain / discard control
    input  logic            DrainEn,
    input  logic            Flush,
    // register file write port
    output logic            RegWr,
    output logic [4:0]      RW,
    output logic [63:0]     BusW,
    // forwarding lookups
    input  logic [4:0]      RA,
    input  logic [4:0]      RB,
    output logic            FwdHitA,
    output logic            FwdHitB,
    output logic [63:0]     FwdDataA,
    output logic [63:0]     FwdDataB,
    // status
    output logic [PTRW:0]   Count,
    output logic            Empty
);

    // X31 is hard-wired to zero, so writes to it are accepted and dropped.
    localparam logic [4:0]    ZERO_REG   = 5'd31;
    localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

    typedef struct packed {
        logic        hit;
        logic [63:0] data;
    } fwd_t;

    // Queue storage; an entry is live only if it lies within Count of the head.
    logic [4:0]      r_ent_reg  [DEPTH];
    logic [63:0]     r_ent_data [DEPTH];

    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [PTRW:0]   r_count;

    // Write-port output stage.
    logic            r_regwr;
    logic [4:0]      r_rw;
    logic [63:0]     r_busw;

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    fwd_t            w_fwd_a;
    fwd_t            w_fwd_b;

    // Handshake uses only registered state, so a pop in the same cycle never
    // opens a slot in a full queue.
    assign WrReady  = (r_count != FULL_COUNT);
    assign w_accept = WrValid && WrReady;

    // Flush wins over both push and pop; X31 requests are consumed silently.
    assign w_push = w_accept && (WrReg != ZERO_REG) && !Flush;
    assign w_pop  = DrainEn && (r_count != '0) && !Flush;

    // Queue pointers and occupancy, wrapping modulo DEPTH.
    always_ff @(posedge Clk or negedge Reset_L) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!Reset_L) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (Flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload written at the tail on every push.
    always_ff @(posedge Clk) begin
        // NOTE: the payload array has no reset; head/tail/count decide which
        // entries are live, so stale contents are never observed.
        if (w_push) begin
            r_ent_reg[r_tail]  <= WrReg;
            r_ent_data[r_tail] <= WrData;
        end
    end

    // Write-port stage: loads the head entry on a pop, otherwise idles with
    // the address and data held from the last write.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_regwr <= 1'b0;
            r_rw    <= ZERO_REG;
            r_busw  <= '0;
        end else if (w_pop) begin
            r_regwr <= 1'b1;
            r_rw    <= r_ent_reg[r_head];
            r_busw  <= r_ent_data[r_head];
        end else begin
            r_regwr <= 1'b0;
        end
    end

    // Forwarding search: start with the write-port stage (oldest pending),
    // then walk the queue oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTRW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_fwd_a = '0;
        w_fwd_b = '0;
        idx     = r_head;

        if (r_regwr && (r_rw == RA)) begin
            w_fwd_a = '{hit: 1'b1, data: r_busw};
        end
        if (r_regwr && (r_rw == RB)) begin
            w_fwd_b = '{hit: 1'b1, data: r_busw};
        end

        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PTRW'(i);
            if ((PTRW + 1)'(i) < r_count) begin
                if (r_ent_reg[idx] == RA) begin
                    w_fwd_a = '{hit: 1'b1, data: r_ent_data[idx]};
                end
                if (r_ent_reg[idx] == RB) begin
                    w_fwd_b = '{hit: 1'b1, data: r_ent_data[idx]};
                end
            end
        end

        // X31 always reads as zero, so it never forwards.
        if (RA == ZERO_REG) begin
            w_fwd_a = '0;
        end
        if (RB == ZERO_REG) begin
            w_fwd_b = '0;
        end
    end

    assign RegWr    = r_regwr;
    assign RW       = r_rw;
    assign BusW     = r_busw;
    assign FwdHitA  = w_fwd_a.hit;
    assign FwdDataA = w_fwd_a.data;
    assign FwdHitB  = w_fwd_b.hit;
    assign FwdDataB = w_fwd_b.data;
    assign Count    = r_count;
    assign Empty    = (r_count == '0) && !r_regwr;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Testbench for regfile_writeback_queue: directed scenarios plus a randomized
// run, all checked against a queue-based reference model of the writeback
// queue and its write-port stage.

module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic            Clk = 1'b0;
    logic            Reset_L;
    logic            WrValid;
    logic            WrReady;
    logic [4:0]      WrReg;
    logic [63:0]     WrData;
    logic            DrainEn;
    logic            Flush;
    logic            RegWr;
    logic [4:0]      RW;
    logic [63:0]     BusW;
    logic [4:0]      RA;
    logic [4:0]      RB;
    logic            FwdHitA;
    logic            FwdHitB;
    logic [63:0]     FwdDataA;
    logic [63:0]     FwdDataB;
    logic [PTRW:0]   Count;
    logic            Empty;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    regfile_writeback_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .Clk      (Clk),
        .Reset_L  (Reset_L),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrReg    (WrReg),
        .WrData   (WrData),
        .DrainEn  (DrainEn),
        .Flush    (Flush),
        .RegWr    (RegWr),
        .RW       (RW),
        .BusW     (BusW),
        .RA       (RA),
        .RB       (RB),
        .FwdHitA  (FwdHitA),
        .FwdHitB  (FwdHitB),
        .FwdDataA (FwdDataA),
        .FwdDataB (FwdDataB),
        .Count    (Count),
        .Empty    (Empty)
    );

    // Reference model: list of pending writes plus the write-port stage.
    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic        m_regwr;
    logic [4:0]  m_rw;
    logic [63:0] m_busw;

    task automatic model_reset();
        m_q.delete();
        m_regwr = 1'b0;
        m_rw    = 5'd31;
        m_busw  = 64'd0;
    endtask

    task automatic set_idle();
        WrValid = 1'b0;
        WrReg   = 5'd0;
        WrData  = 64'd0;
        DrainEn = 1'b0;
        Flush   = 1'b0;
    endtask

    // Advance one clock; the model applies the rules to the inputs seen at
    // the edge, then the bench resumes 1 time unit after the edge.
    task automatic tick();
        ent_t e;
        bit   acc;
        @(posedge Clk);
        if (Reset_L) begin
            acc = WrValid && (m_q.size() < DEPTH);
            if (Flush) begin
                m_q.delete();
                m_regwr = 1'b0;
            end else begin
                if (DrainEn && m_q.size() > 0) begin
                    e       = m_q.pop_front();
                    m_regwr = 1'b1;
                    m_rw    = e.r;
                    m_busw  = e.d;
                end else begin
                    m_regwr = 1'b0;
                end
                if (acc && WrReg != 5'd31) begin
                    e.r = WrReg;
                    e.d = WrData;
                    m_q.push_back(e);
                end
            end
        end
        #1;
    endtask

    // Newest pending value for an address: youngest queued entry first,
    // then the write-port stage; X31 never hits.
    function automatic logic [64:0] m_fwd(input logic [4:0] a);
        if (a == 5'd31) return 65'd0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].r == a) return {1'b1, m_q[i].d};
        end
        if (m_regwr && m_rw == a) return {1'b1, m_busw};
        return 65'd0;
    endfunction

    task automatic test_reset();
        Reset_L = 1'b0;
        set_idle();
        RA = 5'd0;
        RB = 5'd0;
        model_reset();
        repeat (2) tick();
        checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL reset_regwr: got %0b want 0", RegWr); end
        checks++; if (RW !== 5'd31) begin failures++; $display("FAIL reset_rw: got %0d want 31", RW); end
        checks++; if (BusW !== 64'd0) begin failures++; $display("FAIL reset_busw: got %h want 0", BusW); end
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", Count); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b want 1", Empty); end
        checks++; if (WrReady !== 1'b1) begin failures++; $display("FAIL reset_wrready: got %0b want 1", WrReady); end
        Reset_L = 1'b1;
        tick();
        // Build up activity: one write in flight and one still queued.
        WrValid = 1'b1; WrReg = 5'd3; WrData = 64'h55; DrainEn = 1'b1;
        tick();
        WrReg = 5'd4; WrData = 64'h66;
        tick();
        set_idle();
        checks++; if (RegWr !== 1'b1 || RW !== 5'd3) begin failures++; $display("FAIL reset_preact: got regwr=%0b rw=%0d want 1/3", RegWr, RW); end
        checks++; if (Count !== 3'd1) begin failures++; $display("FAIL reset_precount: got %0d want 1", Count); end
        // Asynchronous reset in the middle of the cycle.
        #2;
        Reset_L = 1'b0;
        model_reset();
        #1;
        checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL areset_regwr: got %0b want 0", RegWr); end
        checks++; if (RW !== 5'd31) begin failures++; $display("FAIL areset_rw: got %0d want 31", RW); end
        checks++; if (BusW !== 64'd0) begin failures++; $display("FAIL areset_busw: got %h want 0", BusW); end
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL areset_count: got %0d want 0", Count); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL areset_empty: got %0b want 1", Empty); end
        checks++; if (WrReady !== 1'b1) begin failures++; $display("FAIL areset_wrready: got %0b want 1", WrReady); end
        tick();
        Reset_L = 1'b1;
        DrainEn = 1'b1;
        repeat (2) begin
            tick();
            checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL areset_dropped: got regwr=%0b want 0", RegWr); end
        end
        set_idle();
    endtask

    task automatic test_single_write();
        logic [64:0] exp;
        RA = 5'd5;
        WrValid = 1'b1; WrReg = 5'd5; WrData = 64'h1234; DrainEn = 1'b1;
        #1;
        checks++; if (FwdHitA !== 1'b0) begin failures++; $display("FAIL single_prehit: got %0b want 0", FwdHitA); end
        tick();
        WrValid = 1'b0;
        #1;
        checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL single_minlat: got regwr=%0b want 0", RegWr); end
        checks++; if (Count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d want 1", Count); end
        checks++; if (FwdHitA !== 1'b1 || FwdDataA !== 64'h1234) begin failures++; $display("FAIL single_fwd_queued: got hit=%0b data=%h want 1/1234", FwdHitA, FwdDataA); end
        tick();
        checks++; if (RegWr !== 1'b1 || RW !== 5'd5 || BusW !== 64'h1234) begin failures++; $display("FAIL single_write: got regwr=%0b rw=%0d busw=%h want 1/5/1234", RegWr, RW, BusW); end
        checks++; if (FwdHitA !== 1'b1 || FwdDataA !== 64'h1234) begin failures++; $display("FAIL single_fwd_out: got hit=%0b data=%h want 1/1234", FwdHitA, FwdDataA); end
        checks++; if (Empty !== 1'b0) begin failures++; $display("FAIL single_empty_out: got %0b want 0", Empty); end
        tick();
        exp = m_fwd(RA);
        checks++; if (RegWr !== 1'b0 || RW !== 5'd5) begin failures++; $display("FAIL single_after: got regwr=%0b rw=%0d want 0/5", RegWr, RW); end
        checks++; if (FwdHitA !== exp[64] || FwdDataA !== exp[63:0]) begin failures++; $display("FAIL single_fwd_after: got hit=%0b data=%h want %0b/%h", FwdHitA, FwdDataA, exp[64], exp[63:0]); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL single_empty_after: got %0b want 1", Empty); end
        set_idle();
    endtask

    task automatic test_full_backpressure();
        for (int i = 1; i <= DEPTH; i++) begin
            WrValid = 1'b1; WrReg = 5'(i); WrData = 64'h100 + 64'(i);
            tick();
            checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL full_fill_regwr: got %0b want 0", RegWr); end
        end
        checks++; if (Count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", Count); end
        checks++; if (WrReady !== 1'b0) begin failures++; $display("FAIL full_wrready: got %0b want 0", WrReady); end
        WrReg = 5'd9; WrData = 64'h999;
        tick();
        WrValid = 1'b0;
        checks++; if (Count !== 3'd4) begin failures++; $display("FAIL full_reject: got count=%0d want 4", Count); end
        DrainEn = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            checks++; if (RegWr !== 1'b1 || RW !== 5'(i) || BusW !== 64'h100 + 64'(i)) begin failures++; $display("FAIL full_drain_%0d: got regwr=%0b rw=%0d busw=%h want 1/%0d/%h", i, RegWr, RW, BusW, i, 64'h100 + 64'(i)); end
            checks++; if (WrReady !== 1'b1) begin failures++; $display("FAIL full_ready_%0d: got %0b want 1", i, WrReady); end
        end
        tick();
        checks++; if (RegWr !== 1'b0 || Empty !== 1'b1) begin failures++; $display("FAIL full_done: got regwr=%0b empty=%0b want 0/1", RegWr, Empty); end
        set_idle();
    endtask

    task automatic test_same_register();
        RA = 5'd7; RB = 5'd8;
        WrValid = 1'b1; WrReg = 5'd7; WrData = 64'hA;
        tick();
        WrData = 64'hB;
        tick();
        WrValid = 1'b0;
        #1;
        checks++; if (FwdHitA !== 1'b1 || FwdDataA !== 64'hB) begin failures++; $display("FAIL same_queued: got hit=%0b data=%h want 1/b", FwdHitA, FwdDataA); end
        checks++; if (FwdHitB !== 1'b0 || FwdDataB !== 64'd0) begin failures++; $display("FAIL same_miss_b: got hit=%0b data=%h want 0/0", FwdHitB, FwdDataB); end
        RB = 5'd7;
        DrainEn = 1'b1;
        tick();
        checks++; if (RegWr !== 1'b1 || BusW !== 64'hA) begin failures++; $display("FAIL same_first_out: got regwr=%0b busw=%h want 1/a", RegWr, BusW); end
        checks++; if (FwdHitA !== 1'b1 || FwdDataA !== 64'hB) begin failures++; $display("FAIL same_one_drained: got hit=%0b data=%h want 1/b", FwdHitA, FwdDataA); end
        checks++; if (FwdHitB !== 1'b1 || FwdDataB !== 64'hB) begin failures++; $display("FAIL same_one_drained_b: got hit=%0b data=%h want 1/b", FwdHitB, FwdDataB); end
        tick();
        checks++; if (RegWr !== 1'b1 || BusW !== 64'hB || FwdDataA !== 64'hB) begin failures++; $display("FAIL same_second_out: got regwr=%0b busw=%h fwd=%h want 1/b/b", RegWr, BusW, FwdDataA); end
        tick();
        checks++; if (FwdHitA !== 1'b0 || FwdDataA !== 64'd0) begin failures++; $display("FAIL same_drained: got hit=%0b data=%h want 0/0", FwdHitA, FwdDataA); end
        set_idle();
    endtask

    task automatic test_x31_and_flush();
        RA = 5'd31;
        WrValid = 1'b1; WrReg = 5'd31; WrData = 64'hFFFF; DrainEn = 1'b1;
        #1;
        checks++; if (WrReady !== 1'b1) begin failures++; $display("FAIL x31_ready: got %0b want 1", WrReady); end
        tick();
        WrValid = 1'b0;
        checks++; if (Count !== 3'd0 || Empty !== 1'b1) begin failures++; $display("FAIL x31_count: got count=%0d empty=%0b want 0/1", Count, Empty); end
        checks++; if (FwdHitA !== 1'b0) begin failures++; $display("FAIL x31_fwd: got %0b want 0", FwdHitA); end
        tick();
        checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL x31_nowrite: got regwr=%0b want 0", RegWr); end
        DrainEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            WrValid = 1'b1; WrReg = 5'(10 + i); WrData = 64'hF0 + 64'(i);
            tick();
        end
        checks++; if (Count !== 3'd3) begin failures++; $display("FAIL flush_pre_count: got %0d want 3", Count); end
        Flush = 1'b1; WrReg = 5'd13; WrData = 64'hDEAD; DrainEn = 1'b1;
        #1;
        checks++; if (WrReady !== 1'b1) begin failures++; $display("FAIL flush_ready: got %0b want 1", WrReady); end
        tick();
        Flush = 1'b0; WrValid = 1'b0;
        checks++; if (Count !== 3'd0 || RegWr !== 1'b0 || Empty !== 1'b1) begin failures++; $display("FAIL flush_state: got count=%0d regwr=%0b empty=%0b want 0/0/1", Count, RegWr, Empty); end
        repeat (3) begin
            tick();
            checks++; if (RegWr !== 1'b0) begin failures++; $display("FAIL flush_nowrite: got regwr=%0b want 0", RegWr); end
        end
        set_idle();
    endtask

    task automatic test_wrap_around();
        logic [63:0] sent[$];
        logic [63:0] seen[$];
        logic [63:0] v;
        int          cyc;
        // Prime with one entry, then alternate push-only / drain-only cycles.
        v = {$urandom, $urandom};
        sent.push_back(v);
        WrValid = 1'b1; WrReg = 5'd1; WrData = v; DrainEn = 1'b0;
        tick();
        for (int k = 1; k < 10; k++) begin
            v = {$urandom, $urandom};
            sent.push_back(v);
            WrValid = 1'b1; WrReg = 5'(1 + k % 6); WrData = v; DrainEn = 1'b0;
            tick();
            if (RegWr === 1'b1) seen.push_back(BusW);
            checks++; if (Count !== 3'd2) begin failures++; $display("FAIL wrap_count_hi: got %0d want 2", Count); end
            WrValid = 1'b0; DrainEn = 1'b1;
            tick();
            if (RegWr === 1'b1) seen.push_back(BusW);
            checks++; if (Count !== 3'd1) begin failures++; $display("FAIL wrap_count_lo: got %0d want 1", Count); end
        end
        cyc = 0;
        while ((m_q.size() > 0 || m_regwr) && cyc < 20) begin
            tick();
            if (RegWr === 1'b1) seen.push_back(BusW);
            cyc++;
        end
        checks++; if (seen.size() != sent.size()) begin failures++; $display("FAIL wrap_len: got %0d writes want %0d", seen.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < seen.size(); i++) begin
            checks++; if (seen[i] !== sent[i]) begin failures++; $display("FAIL wrap_order_%0d: got %h want %h", i, seen[i], sent[i]); end
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [64:0] exp_a;
        logic [64:0] exp_b;
        for (int n = 0; n < 300; n++) begin
            WrValid = 1'($urandom_range(0, 1));
            WrReg   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            WrData  = {$urandom, $urandom};
            DrainEn = ($urandom_range(0, 2) != 0);
            Flush   = ($urandom_range(0, 24) == 0);
            RA      = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            RB      = 5'($urandom_range(0, 7));
            #1;
            exp_a = m_fwd(RA);
            exp_b = m_fwd(RB);
            checks++; if (WrReady !== (m_q.size() < DEPTH)) begin failures++; $display("FAIL rnd_wrready @%0d: got %0b want %0b", n, WrReady, m_q.size() < DEPTH); end
            checks++; if (Count !== (PTRW + 1)'(m_q.size())) begin failures++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, Count, m_q.size()); end
            checks++; if (Empty !== (m_q.size() == 0 && !m_regwr)) begin failures++; $display("FAIL rnd_empty @%0d: got %0b", n, Empty); end
            checks++; if (RegWr !== m_regwr) begin failures++; $display("FAIL rnd_regwr @%0d: got %0b want %0b", n, RegWr, m_regwr); end
            checks++; if (RW !== m_rw || BusW !== m_busw) begin failures++; $display("FAIL rnd_port @%0d: got rw=%0d busw=%h want %0d/%h", n, RW, BusW, m_rw, m_busw); end
            checks++; if (FwdHitA !== exp_a[64] || FwdDataA !== exp_a[63:0]) begin failures++; $display("FAIL rnd_fwd_a @%0d: got %0b/%h want %0b/%h", n, FwdHitA, FwdDataA, exp_a[64], exp_a[63:0]); end
            checks++; if (FwdHitB !== exp_b[64] || FwdDataB !== exp_b[63:0]) begin failures++; $display("FAIL rnd_fwd_b @%0d: got %0b/%h want %0b/%h", n, FwdHitB, FwdDataB, exp_b[64], exp_b[63:0]); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_backpressure();
        test_same_register();
        test_x31_and_flush();
        test_wrap_around();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
